trap_ctrl: RTL and testbench

- Sequences machine-mode trap entry and MRET return for the single-hart M-only core.
- Arbitrates between three sources:
  - synchronous exceptions from the pipeline,
  - level-sensitive interrupt lines,
  - MRET retirement.
- Drives the hardware write-enable ports of the machine CSR register block (mstatus/mepc/mcause/mtval).
- Issues a flush plus PC redirect to the fetch stage.

---
 rtl/trap_pkg.sv | 33 +++
 rtl/trap_irq_prio.sv | 28 ++
 rtl/trap_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller:
// FSM state encoding, mcause codes and mtvec mode values.
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ENTER    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_RETURN   = 2'd3
    } trap_state_e;

    // Interrupt cause codes (mcause with interrupt bit set)
    localparam int CAUSE_MSI = 3;
    localparam int CAUSE_MTI = 7;
    localparam int CAUSE_MEI = 11;

    // Synchronous exception cause codes; code 10 is reserved
    localparam int EXC_INSN_MISALIGN  = 0;
    localparam int EXC_INSN_FAULT     = 1;
    localparam int EXC_ILLEGAL_INSN   = 2;
    localparam int EXC_BREAKPOINT     = 3;
    localparam int EXC_LOAD_MISALIGN  = 4;
    localparam int EXC_LOAD_FAULT     = 5;
    localparam int EXC_STORE_MISALIGN = 6;
    localparam int EXC_STORE_FAULT    = 7;
    localparam int EXC_ECALL_U        = 8;
    localparam int EXC_ECALL_S        = 9;
    localparam int EXC_ECALL_M        = 11;

    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

endpackage

// File: rtl/trap_irq_prio.sv
// Masks the interrupt lines with mstatus.MIE and picks one winner:
// external > software > timer.
module trap_irq_prio
    import trap_pkg::*;
#(
    parameter int CAUSE_W = 31
) (
    input  logic               irq_ext,
    input  logic               irq_sw,
    input  logic               irq_timer,
    input  logic               mstatus_mie,
    output logic               irq_take,
    output logic [CAUSE_W-1:0] irq_code
);

    always_comb begin
        irq_take = mstatus_mie & (irq_ext | irq_sw | irq_timer);
        irq_code = '0;
        if (irq_ext) begin
            irq_code = CAUSE_W'(CAUSE_MEI);
        end else if (irq_sw) begin
            irq_code = CAUSE_W'(CAUSE_MSI);
        end else if (irq_timer) begin
            irq_code = CAUSE_W'(CAUSE_MTI);
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap entry / MRET sequencer driving CSR write ports and the
// fetch redirect. Define TRAP_CTRL_VECTOR_EN to enable vectored interrupt targets.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int CAUSE_W = 31
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exc_valid,
    input  logic [CAUSE_W-1:0] exc_code,
    input  logic [XLEN-1:0]    exc_pc,
    input  logic [XLEN-1:0]    exc_tval,
    input  logic               mret_valid,
    input  logic [XLEN-1:0]    next_pc,
    input  logic               irq_ext,
    input  logic               irq_sw,
    input  logic               irq_timer,
    input  logic               mstatus_mie,
    input  logic               mstatus_mpie,
    input  logic [29:0]        mtvec_base,
    input  logic [1:0]         mtvec_mode,
    input  logic [XLEN-1:0]    mepc_value,
    output logic [XLEN-1:0]    o_mepc_value,
    output logic               o_mepc_wen,
    output logic               o_mcause_interrupt,
    output logic               o_mcause_interrupt_wen,
    output logic [CAUSE_W-1:0] o_mcause_code,
    output logic               o_mcause_code_wen,
    output logic [XLEN-1:0]    o_mtval_value,
    output logic               o_mtval_wen,
    output logic               o_mstatus_mie,
    output logic               o_mstatus_mie_wen,
    output logic               o_mstatus_mpie,
    output logic               o_mstatus_mpie_wen,
    output logic               busy,
    output logic               flush,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc
);

    trap_state_e        state_q, state_d;
    logic               cap_int_q, cap_int_d;
    logic [CAUSE_W-1:0] cap_code_q, cap_code_d;
    logic [XLEN-1:0]    cap_pc_q, cap_pc_d;
    logic [XLEN-1:0]    cap_tval_q, cap_tval_d;
    logic               cap_mie_q, cap_mie_d;

    logic               irq_take;
    logic [CAUSE_W-1:0] irq_code;

    logic [XLEN-1:0]    mepc_d, mtval_d, redirect_pc_d;
    logic [CAUSE_W-1:0] mcause_code_d;
    logic               mcause_int_d, mie_d, mpie_d;
    logic [5:0]         wen_d;
    logic               busy_d, flush_d, redirect_valid_d;

    logic [XLEN-1:0]    base_addr, trap_target;

    trap_irq_prio #(.CAUSE_W(CAUSE_W)) u_prio (
        .irq_ext     (irq_ext),
        .irq_sw      (irq_sw),
        .irq_timer   (irq_timer),
        .mstatus_mie (mstatus_mie),
        .irq_take    (irq_take),
        .irq_code    (irq_code)
    );

    assign base_addr = XLEN'({mtvec_base, 2'b00});

`ifdef TRAP_CTRL_VECTOR_EN
    // Vectored offset applies to interrupts only; exceptions land on the base
    logic [XLEN-1:0] vec_off;
    assign vec_off     = XLEN'(cap_code_q) << 2;
    assign trap_target = (cap_int_q && mtvec_mode == MTVEC_VECTORED) ?
                         base_addr + vec_off : base_addr;
`else
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_mode;
    assign trap_target       = base_addr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cap_int_q  <= 1'b0;
            cap_code_q <= '0;
            cap_pc_q   <= '0;
            cap_tval_q <= '0;
            cap_mie_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cap_int_q  <= cap_int_d;
            cap_code_q <= cap_code_d;
            cap_pc_q   <= cap_pc_d;
            cap_tval_q <= cap_tval_d;
            cap_mie_q  <= cap_mie_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cap_int_d  = cap_int_q;
        cap_code_d = cap_code_q;
        cap_pc_d   = cap_pc_q;
        cap_tval_d = cap_tval_q;
        cap_mie_d  = cap_mie_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_valid) begin
                    cap_int_d  = 1'b0;
                    cap_code_d = exc_code;
                    cap_pc_d   = exc_pc;
                    cap_tval_d = exc_tval;
                    cap_mie_d  = mstatus_mie;
                    state_d    = ST_ENTER;
                end else if (irq_take) begin
                    cap_int_d  = 1'b1;
                    cap_code_d = irq_code;
                    cap_pc_d   = next_pc;
                    cap_tval_d = '0;
                    cap_mie_d  = mstatus_mie;
                    state_d    = ST_ENTER;
                end else if (mret_valid) begin
                    state_d    = ST_RETURN;
                end
            end
            ST_ENTER:    state_d = ST_REDIRECT;
            ST_REDIRECT: state_d = ST_IDLE;
            ST_RETURN:   state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output values are computed for the state being entered so every port is a flop
    always_comb begin
        mepc_d           = '0;
        mcause_int_d     = 1'b0;
        mcause_code_d    = '0;
        mtval_d          = '0;
        mie_d            = 1'b0;
        mpie_d           = 1'b0;
        wen_d            = 6'b0;
        busy_d           = 1'b0;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;
        case (state_d)
            ST_ENTER: begin
                wen_d         = 6'b11_1111;
                mepc_d        = cap_pc_d;
                mcause_int_d  = cap_int_d;
                mcause_code_d = cap_code_d;
                mtval_d       = cap_tval_d;
                mpie_d        = cap_mie_d;
                busy_d        = 1'b1;
                flush_d       = 1'b1;
            end
            ST_REDIRECT: begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = trap_target;
                busy_d           = 1'b1;
                flush_d          = 1'b1;
            end
            ST_RETURN: begin
                wen_d            = 6'b00_0011;
                mie_d            = mstatus_mpie;
                mpie_d           = 1'b1;
                redirect_valid_d = 1'b1;
                redirect_pc_d    = mepc_value;
                busy_d           = 1'b1;
                flush_d          = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_mepc_value           <= '0;
            o_mcause_interrupt     <= 1'b0;
            o_mcause_code          <= '0;
            o_mtval_value          <= '0;
            o_mstatus_mie          <= 1'b0;
            o_mstatus_mpie         <= 1'b0;
            o_mepc_wen             <= 1'b0;
            o_mcause_interrupt_wen <= 1'b0;
            o_mcause_code_wen      <= 1'b0;
            o_mtval_wen            <= 1'b0;
            o_mstatus_mie_wen      <= 1'b0;
            o_mstatus_mpie_wen     <= 1'b0;
            busy                   <= 1'b0;
            flush                  <= 1'b0;
            redirect_valid         <= 1'b0;
            redirect_pc            <= '0;
        end else begin
            o_mepc_value           <= mepc_d;
            o_mcause_interrupt     <= mcause_int_d;
            o_mcause_code          <= mcause_code_d;
            o_mtval_value          <= mtval_d;
            o_mstatus_mie          <= mie_d;
            o_mstatus_mpie         <= mpie_d;
            o_mepc_wen             <= wen_d[5];
            o_mcause_interrupt_wen <= wen_d[4];
            o_mcause_code_wen      <= wen_d[3];
            o_mtval_wen            <= wen_d[2];
            o_mstatus_mie_wen      <= wen_d[1];
            o_mstatus_mpie_wen     <= wen_d[0];
            busy                   <= busy_d;
            flush                  <= flush_d;
            redirect_valid         <= redirect_valid_d;
            redirect_pc            <= redirect_pc_d;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed plus randomized bench for trap_ctrl against a rule-level model.
module tb_trap_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        exc_valid, mret_valid;
    logic [30:0] exc_code;
    logic [31:0] exc_pc, exc_tval, next_pc, mepc_value;
    logic        irq_ext, irq_sw, irq_timer, mstatus_mie, mstatus_mpie;
    logic [29:0] mtvec_base;
    logic [1:0]  mtvec_mode;
    logic [31:0] o_mepc_value, o_mtval_value, redirect_pc;
    logic        o_mepc_wen, o_mcause_interrupt, o_mcause_interrupt_wen;
    logic [30:0] o_mcause_code;
    logic        o_mcause_code_wen, o_mtval_wen;
    logic        o_mstatus_mie, o_mstatus_mie_wen, o_mstatus_mpie, o_mstatus_mpie_wen;
    logic        busy, flush, redirect_valid;

    int errors = 0;
    int checks = 0;
    int txn_no = 0;

    trap_ctrl dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret_valid(mret_valid), .next_pc(next_pc),
        .irq_ext(irq_ext), .irq_sw(irq_sw), .irq_timer(irq_timer),
        .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie),
        .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode), .mepc_value(mepc_value),
        .o_mepc_value(o_mepc_value), .o_mepc_wen(o_mepc_wen),
        .o_mcause_interrupt(o_mcause_interrupt), .o_mcause_interrupt_wen(o_mcause_interrupt_wen),
        .o_mcause_code(o_mcause_code), .o_mcause_code_wen(o_mcause_code_wen),
        .o_mtval_value(o_mtval_value), .o_mtval_wen(o_mtval_wen),
        .o_mstatus_mie(o_mstatus_mie), .o_mstatus_mie_wen(o_mstatus_mie_wen),
        .o_mstatus_mpie(o_mstatus_mpie), .o_mstatus_mpie_wen(o_mstatus_mpie_wen),
        .busy(busy), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] wens();
        return {o_mepc_wen, o_mcause_interrupt_wen, o_mcause_code_wen,
                o_mtval_wen, o_mstatus_mie_wen, o_mstatus_mpie_wen};
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_flush"}, 64'(flush), 64'd0);
        chk({tag, "_redir"}, 64'(redirect_valid), 64'd0);
        chk({tag, "_wens"}, 64'(wens()), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_quiet(tag);
        chk({tag, "_vals"}, {o_mepc_value, o_mtval_value}, 64'd0);
        chk({tag, "_pc"}, 64'(redirect_pc), 64'd0);
        chk({tag, "_misc"}, 64'({o_mcause_interrupt, o_mcause_code, o_mstatus_mie, o_mstatus_mpie}), 64'd0);
    endtask

    task automatic clear_inputs();
        exc_valid = 0; exc_code = '0; exc_pc = '0; exc_tval = '0; mret_valid = 0;
        next_pc = '0; irq_ext = 0; irq_sw = 0; irq_timer = 0;
        mstatus_mie = 0; mstatus_mpie = 0; mtvec_base = '0; mtvec_mode = '0; mepc_value = '0;
    endtask

    // irq = {ext, sw, timer}
    task automatic run_txn(input bit ev, input logic [30:0] ec, input logic [31:0] epc,
                           input logic [31:0] etv, input bit mr, input logic [2:0] irq,
                           input bit mie, input bit mpie, input logic [31:0] npc,
                           input logic [29:0] base, input logic [1:0] mode,
                           input logic [31:0] mepc);
        int          kind;
        logic [30:0] code;
        logic [31:0] exp_pc, exp_tval, target;
        kind = 0; code = '0; exp_pc = '0; exp_tval = '0;
        if (ev) begin
            kind = 1; code = ec; exp_pc = epc; exp_tval = etv;
        end else if (mie && irq != 3'b000) begin
            kind = 2; exp_pc = npc; exp_tval = 32'd0;
            code = irq[2] ? 31'd11 : (irq[1] ? 31'd3 : 31'd7);
        end else if (mr) begin
            kind = 3;
        end
        target = {base, 2'b00};
`ifdef TRAP_CTRL_VECTOR_EN
        if (kind == 2 && mode == 2'd1) target = target + 32'(code) * 32'd4;
`endif
        exc_valid = ev; exc_code = ec; exc_pc = epc; exc_tval = etv; mret_valid = mr;
        {irq_ext, irq_sw, irq_timer} = irq; mstatus_mie = mie; mstatus_mpie = mpie;
        next_pc = npc; mtvec_base = base; mtvec_mode = mode; mepc_value = mepc;
        txn_no++;
        $display("txn %0d kind=%0d code=%0d pc=%h target=%h", txn_no, kind, code, exp_pc,
                 (kind == 3) ? mepc : target);
        tick();
        exc_valid = 0; mret_valid = 0; irq_ext = 0; irq_sw = 0; irq_timer = 0;
        case (kind)
            0: check_quiet("none");
            1, 2: begin
                chk("enter_wens", 64'(wens()), 64'h3f);
                chk("enter_mepc", 64'(o_mepc_value), 64'(exp_pc));
                chk("enter_mcause", 64'({o_mcause_interrupt, o_mcause_code}),
                    64'({kind == 2, code}));
                chk("enter_mtval", 64'(o_mtval_value), 64'(exp_tval));
                chk("enter_mstatus", 64'({o_mstatus_mie, o_mstatus_mpie}), 64'({1'b0, mie}));
                chk("enter_ctl", 64'({busy, flush, redirect_valid}), 64'b110);
                tick();
                chk("redir_ctl", 64'({busy, flush, redirect_valid}), 64'b111);
                chk("redir_wens", 64'(wens()), 64'd0);
                chk("redir_pc", 64'(redirect_pc), 64'(target));
                tick();
                check_quiet("trap_idle");
            end
            default: begin
                chk("mret_wens", 64'(wens()), 64'h03);
                chk("mret_mstatus", 64'({o_mstatus_mie, o_mstatus_mpie}), 64'({mpie, 1'b1}));
                chk("mret_ctl", 64'({busy, flush, redirect_valid}), 64'b111);
                chk("mret_pc", 64'(redirect_pc), 64'(mepc));
                tick();
                check_quiet("mret_idle");
            end
        endcase
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        tick(); tick();
        check_all_zero("reset");
        rst = 0;
        tick();
        check_all_zero("post_reset");

        // Exception, direct target
        run_txn(1, 31'd2, 32'h100, 32'hDEADBEEF, 0, 3'b000, 1, 0, 32'h0, 30'h2000_0000, 2'd0, 32'h0);
        // Timer interrupt with vectored mode
        run_txn(0, 31'd0, 32'h0, 32'h0, 0, 3'b001, 1, 0, 32'h204, 30'h2000_0000, 2'd1, 32'h0);
        // Exception beats all interrupts, then ext wins among interrupts
        run_txn(1, 31'd11, 32'h400, 32'h55, 0, 3'b111, 1, 1, 32'h404, 30'h2000_0000, 2'd1, 32'h0);
        run_txn(0, 31'd0, 32'h0, 32'h0, 0, 3'b111, 1, 1, 32'h404, 30'h2000_0000, 2'd1, 32'h0);
        // Software beats timer
        run_txn(0, 31'd0, 32'h0, 32'h0, 0, 3'b011, 1, 0, 32'h508, 30'h2000_0000, 2'd1, 32'h0);
        // Vectored wrap modulo 2^32
        run_txn(0, 31'd0, 32'h0, 32'h0, 0, 3'b100, 1, 0, 32'h60C, 30'h3FFF_FFFF, 2'd1, 32'h0);

        // Masked interrupts must never start a trap
        clear_inputs();
        {irq_ext, irq_sw, irq_timer} = 3'b111;
        mstatus_mie = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("masked_busy", 64'({busy, wens()}), 64'd0);
        end
        clear_inputs();

        // MRET
        run_txn(0, 31'd0, 32'h0, 32'h0, 1, 3'b000, 0, 1, 32'h0, 30'h2000_0000, 2'd0, 32'h300);

        // Reset while in ENTER
        exc_valid = 1; exc_code = 31'd5; exc_pc = 32'h700; exc_tval = 32'h1234;
        mstatus_mie = 1; mtvec_base = 30'h0000_1000;
        tick();
        exc_valid = 0;
        chk("pre_rst_enter", 64'(wens()), 64'h3f);
        rst = 1;
        tick();
        check_all_zero("rst_mid");
        rst = 0;
        tick();
        check_quiet("rst_mid_idle");
        run_txn(1, 31'd7, 32'h800, 32'hCAFE, 0, 3'b000, 1, 1, 32'h0, 30'h0000_1000, 2'd0, 32'h0);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            logic [2:0] rirq;
            rirq = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            run_txn($urandom_range(0, 3) == 0, 31'($urandom_range(0, 11)), $urandom, $urandom,
                    $urandom_range(0, 1) == 1, rirq, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom, 30'($urandom),
                    2'($urandom_range(0, 3)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
